rw_timing_fsm: RTL and testbench

RW_TIMING_FSM -- requirements
Module: rw_timing_fsm

---
 rtl/rw_timing_if.sv | 24 ++
 rtl/rw_timing_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_rw_timing_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rw_timing_if.sv
// Host-side request/command-pulse bundle for rw_timing_fsm.
// The host drives the master modport; the timing FSM takes the slave modport.
interface rw_timing_if;
    logic        cmd_rdy;
    logic [1:0]  req;
    logic [1:0]  bg_addr;
    logic [1:0]  ba_addr;
    logic [13:0] row_addr;
    logic        busy;
    logic        act_rdy;
    logic        no_act_rdy;
    logic        pre_rdy;
    logic        cas_rdy;

    modport master (
        output cmd_rdy, req, bg_addr, ba_addr, row_addr,
        input  busy, act_rdy, no_act_rdy, pre_rdy, cas_rdy
    );

    modport slave (
        input  cmd_rdy, req, bg_addr, ba_addr, row_addr,
        output busy, act_rdy, no_act_rdy, pre_rdy, cas_rdy
    );
endinterface

// File: rtl/rw_timing_fsm.sv
// Single-request DRAM timing sequencer: ACT/PRE/CAS pulses spaced by tRCD, tRP, tRAS, tCCD.
// Define ROW_HIT_EN for open-page operation; otherwise every access closes its row.
module rw_timing_fsm #(
    parameter int T_RCD = 11,
    parameter int T_RP  = 11,
    parameter int T_RAS = 28,
    parameter int T_CCD = 4
) (
    input  logic       CK_c,
    input  logic       reset,
    rw_timing_if.slave bus
);
    localparam logic [5:0] RCD_LD = 6'(T_RCD - 1);
    localparam logic [5:0] RP_LD  = 6'(T_RP - 1);
    localparam logic [5:0] RAS_LD = 6'(T_RAS - 1);
    localparam logic [5:0] CCD_LD = 6'(T_CCD - 1);

    typedef enum logic [2:0] {
        IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CCD
    } state_t;

`ifdef ROW_HIT_EN
    localparam state_t AFTER_RP = ACT;
`else
    localparam state_t AFTER_RP = IDLE;
`endif

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  bank_q, bank_d;
    logic [5:0]  tras_q [16];
    logic [3:0]  bank_in;
    logic        tras_ok;
    logic        act_p, no_act_p, pre_p, cas_p;

    assign bank_in = {bus.bg_addr, bus.ba_addr};
    assign tras_ok = (tras_q[bank_q] == 6'd0);

`ifdef ROW_HIT_EN
    logic [1:0]  req_q, req_d;
    logic [13:0] row_q, row_d;
    logic        hit_q, hit_d;
    logic [15:0] vld_q;
    logic [13:0] tbl_q [16];
    logic        in_vld, in_hit, auto_pre;

    assign in_vld   = vld_q[bank_in];
    assign in_hit   = in_vld && (tbl_q[bank_in] == bus.row_addr);
    // RDA_R and WRA_R are the encodings with bit 1 set
    assign auto_pre = req_q[1];
`else
    logic unused_in;
    assign unused_in = ^{bus.req, bus.row_addr};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != 6'd0) ? cnt_q - 6'd1 : cnt_q;
        bank_d   = bank_q;
        act_p    = 1'b0;
        no_act_p = 1'b0;
        pre_p    = 1'b0;
        cas_p    = 1'b0;
`ifdef ROW_HIT_EN
        req_d    = req_q;
        row_d    = row_q;
        hit_d    = hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    bank_d = bank_in;
`ifdef ROW_HIT_EN
                    req_d = bus.req;
                    row_d = bus.row_addr;
                    hit_d = in_hit;
                    if (in_vld && !in_hit) begin
                        state_d = PRE;
                        cnt_d   = RP_LD;
                    end else begin
                        state_d = ACT;
                        cnt_d   = RCD_LD;
                    end
`else
                    state_d = ACT;
                    cnt_d   = RCD_LD;
`endif
                end
            end
            PRE: begin
                // tRP countdown is frozen until the bank's tRAS window has closed
                if (tras_ok) begin
                    pre_p = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d = AFTER_RP;
                        cnt_d   = RCD_LD;
                    end else begin
                        state_d = WAIT_RP;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT_RP: begin
                if (cnt_q == 6'd0) begin
                    state_d = AFTER_RP;
                    cnt_d   = RCD_LD;
                end
            end
            ACT: begin
`ifdef ROW_HIT_EN
                if (hit_q) begin
                    no_act_p = 1'b1;
                    state_d  = CAS;
                    cnt_d    = CCD_LD;
                end else
`endif
                begin
                    act_p = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d = CAS;
                        cnt_d   = CCD_LD;
                    end else begin
                        state_d = WAIT_RCD;
                    end
                end
            end
            WAIT_RCD: begin
                if (cnt_q == 6'd0) begin
                    state_d = CAS;
                    cnt_d   = CCD_LD;
                end
            end
            CAS: begin
                cas_p = 1'b1;
`ifdef ROW_HIT_EN
                state_d = (cnt_q == 6'd0) ? IDLE : WAIT_CCD;
`else
                state_d = PRE;
                cnt_d   = RP_LD;
`endif
            end
            WAIT_CCD: begin
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK_c or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            bank_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

    always_ff @(posedge CK_c or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) tras_q[i] <= 6'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (act_p && (bank_q == 4'(i))) tras_q[i] <= RAS_LD;
                else if (tras_q[i] != 6'd0)     tras_q[i] <= tras_q[i] - 6'd1;
            end
        end
    end

`ifdef ROW_HIT_EN
    always_ff @(posedge CK_c or posedge reset) begin
        if (reset) begin
            req_q <= 2'd0;
            row_q <= 14'd0;
            hit_q <= 1'b0;
            vld_q <= 16'd0;
            for (int i = 0; i < 16; i++) tbl_q[i] <= 14'd0;
        end else begin
            req_q <= req_d;
            row_q <= row_d;
            hit_q <= hit_d;
            if (act_p) begin
                vld_q[bank_q] <= 1'b1;
                tbl_q[bank_q] <= row_q;
            end else if (pre_p || (cas_p && auto_pre)) begin
                vld_q[bank_q] <= 1'b0;
            end
        end
    end
`endif

    assign bus.busy       = (state_q != IDLE);
    assign bus.act_rdy    = act_p;
    assign bus.no_act_rdy = no_act_p;
    assign bus.pre_rdy    = pre_p;
    assign bus.cas_rdy    = cas_p;
endmodule

// File: tb/tb_rw_timing_fsm.sv
// Randomized bench for rw_timing_fsm against an event-time reference model
// (per-request pulse schedule computed from the timing rules; open-row table as arrays).
module tb_rw_timing_fsm;
    localparam int T_RCD = 11;
    localparam int T_RP  = 11;
    localparam int T_RAS = 28;
    localparam int T_CCD = 4;
    localparam logic [1:0] WR_R = 2'd0, RD_R = 2'd1, WRA_R = 2'd2, RDA_R = 2'd3;

    logic CK_c  = 1'b0;
    logic reset = 1'b1;

    rw_timing_if bus();

    rw_timing_fsm #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CCD(T_CCD)) dut (
        .CK_c (CK_c),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CK_c = ~CK_c;

    int total = 0;
    int bad   = 0;

    longint cyc = 0;
    longint acc_t = -1, free_at = 0, a_t = -1, n_t = -1, p_t = -1, c_t = -1;
    bit          open_v   [16];
    logic [13:0] open_row [16];
    longint      last_act [16];
    bit          accepted_now;

    longint obs_act = -1, obs_noact = -1, obs_pre = -1, obs_cas = -1, obs_busy_hi = -1;
    int     n_act = 0, n_cas = 0;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    function automatic longint lmax(input longint x, input longint y);
        return (x > y) ? x : y;
    endfunction

    task automatic model_reset();
        acc_t = -1; a_t = -1; n_t = -1; p_t = -1; c_t = -1;
        free_at = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            open_v[i]   = 1'b0;
            open_row[i] = 14'd0;
            last_act[i] = -1000;
        end
    endtask

    task automatic model_accept(input logic [1:0] q, input int b, input logic [13:0] r);
        acc_t = cyc; a_t = -1; n_t = -1; p_t = -1;
`ifdef ROW_HIT_EN
        if (open_v[b] && open_row[b] == r) begin
            n_t = cyc + 1;
            c_t = cyc + 2;
        end else begin
            if (open_v[b]) begin
                p_t = lmax(cyc + 1, last_act[b] + T_RAS);
                a_t = p_t + T_RP;
            end else begin
                a_t = cyc + 1;
            end
            c_t = a_t + T_RCD;
            last_act[b] = a_t;
            open_v[b]   = 1'b1;
            open_row[b] = r;
        end
        if (q == RDA_R || q == WRA_R) open_v[b] = 1'b0;
        free_at = c_t + T_CCD;
`else
        a_t = cyc + 1;
        c_t = a_t + T_RCD;
        p_t = lmax(c_t + 1, a_t + T_RAS);
        free_at = p_t + T_RP;
`endif
    endtask

    task automatic tick(input bit c, input logic [1:0] q, input logic [1:0] g, input logic [1:0] ba,
                        input logic [13:0] r, input bit rs);
        logic [4:0] want, got;
        bit busy_w;
        @(posedge CK_c);
        #1;
        cyc++;
        reset        = rs;
        bus.cmd_rdy  = c;
        bus.req      = q;
        bus.bg_addr  = g;
        bus.ba_addr  = ba;
        bus.row_addr = r;
        accepted_now = 1'b0;
        if (rs) model_reset();
        else if (c && cyc >= free_at) begin
            model_accept(q, int'({g, ba}), r);
            accepted_now = 1'b1;
        end
        @(negedge CK_c);
        busy_w = (acc_t >= 0) && (cyc > acc_t) && (cyc < free_at);
        want = {busy_w, cyc == a_t, cyc == n_t, cyc == p_t, cyc == c_t};
        got  = {bus.busy, bus.act_rdy, bus.no_act_rdy, bus.pre_rdy, bus.cas_rdy};
        check(rs ? "reset_outs" : "outs", got, want);
        if (bus.act_rdy)    begin obs_act = cyc; n_act++; end
        if (bus.cas_rdy)    begin obs_cas = cyc; n_cas++; end
        if (bus.no_act_rdy) obs_noact = cyc;
        if (bus.pre_rdy)    obs_pre = cyc;
        if (bus.busy)       obs_busy_hi = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 2'd0, 2'd0, 14'd0, 1'b0);
    endtask

    task automatic send(input logic [1:0] q, input logic [1:0] g, input logic [1:0] ba,
                        input logic [13:0] r, output longint t);
        int n = 0;
        do begin
            tick(1'b1, q, g, ba, r, 1'b0);
            n++;
        end while (!accepted_now && n < 300);
        check("accept_bound", accepted_now, 1);
        t = acc_t;
    endtask

    task automatic drain();
        int n = 0;
        while (cyc < free_at && n < 1000) begin
            tick(1'b0, 2'd0, 2'd0, 2'd0, 14'd0, 1'b0);
            n++;
        end
    endtask

    initial begin
        longint t0, t1, t2, ta, tb, tr, ts;
        bit rs;
        bus.cmd_rdy = 1'b0; bus.req = 2'd0; bus.bg_addr = 2'd0; bus.ba_addr = 2'd0; bus.row_addr = 14'd0;
        model_reset();
        repeat (3) tick(1'b0, 2'd0, 2'd0, 2'd0, 14'd0, 1'b1);

        send(RD_R, 2'd0, 2'd0, 14'd5, t0);
`ifdef ROW_HIT_EN
        send(WR_R, 2'd0, 2'd0, 14'd5, t1);
        check("first_act", obs_act - t0, 1);
        check("first_cas", obs_cas - t0, 12);
        check("first_busy_last", obs_busy_hi - t0, 15);
        n_act = 0;
        send(RD_R, 2'd0, 2'd0, 14'd9, t2);
        check("hit_noact", obs_noact - t1, 1);
        check("hit_cas", obs_cas - t1, 2);
        check("hit_act_count", n_act, 0);
        drain();
        check("conflict_pre", obs_pre - t0, 29);
        check("conflict_act", obs_act - t0, 40);
        check("conflict_cas", obs_cas - t0, 51);
`else
        send(RD_R, 2'd0, 2'd0, 14'd5, t1);
        check("first_act", obs_act - t0, 1);
        check("first_cas", obs_cas - t0, 12);
        check("first_pre", obs_pre - t0, 29);
        check("first_busy_last", obs_busy_hi - t0, 39);
        drain();
        check("second_act", obs_act - t1, 1);
        check("second_pre", obs_pre - t1, 29);
`endif

        n_act = 0;
        send(RDA_R, 2'd1, 2'd2, 14'd3, ta);
        send(RD_R, 2'd1, 2'd2, 14'd3, tb);
        drain();
        check("autopre_act_count", n_act, 2);

        send(RD_R, 2'd2, 2'd1, 14'd7, tr);
        idle(4);
        n_cas = 0;
        tick(1'b0, 2'd0, 2'd0, 2'd0, 14'd0, 1'b1);
        idle(20);
        check("abort_cas_count", n_cas, 0);
        send(RD_R, 2'd2, 2'd1, 14'd7, ts);
        drain();
        check("after_abort_act", obs_act - ts, 1);

        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 599) == 0);
            tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                 2'($urandom_range(0, 1)), 14'(3 + 3 * $urandom_range(0, 2)), rs);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
